// File: rtl/systolic_ctrl_gen.sv
// Job sequencer for a parametrised systolic array: load, one wait cycle, then
// rolling (fill phase followed by write-out of sets_lat * ROWS_PER_SET rows).
module systolic_ctrl_gen #(
  parameter int ARRAY_SIZE   = 256,
  parameter int ROWS_PER_SET = 64,
  parameter int MAX_SETS     = 4,
  parameter int ADDR_W       = 7,
  localparam int IDX_W = $clog2(ROWS_PER_SET),
  localparam int SET_W = $clog2(MAX_SETS) + 1,
  localparam int CYC_W = $clog2(ARRAY_SIZE + 2 + MAX_SETS * ROWS_PER_SET)
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              tpu_start,
  input  logic [SET_W-1:0]  num_sets,
  input  logic              stall,
  input  logic              abort,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] addr_serial_num,
  output logic              alu_start,
  output logic [CYC_W-1:0]  cycle_num,
  output logic [IDX_W-1:0]  matrix_index,
  output logic [SET_W-1:0]  data_set,
  output logic              busy,
  output logic              tpu_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT1   = 2'd2,
    ROLLING = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0]  FILL_CYCLES = CYC_W'(ARRAY_SIZE + 1);
  localparam logic [CYC_W-1:0]  CYC_MAX     = {CYC_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_MAX    = {ADDR_W{1'b1}};
  localparam logic [IDX_W-1:0]  LAST_ROW    = IDX_W'(ROWS_PER_SET - 1);
  localparam logic [SET_W-1:0]  SETS_CAP    = SET_W'(MAX_SETS);

  state_t             state;
  logic [SET_W-1:0]   sets_lat;

  logic               rolling_go;
  logic               write_go;
  logic               last_row;
  logic               last_set;
  logic               job_end;
  logic [CYC_W-1:0]   cycle_inc;
  logic [ADDR_W-1:0]  addr_inc;
  logic [IDX_W-1:0]   index_next;
  logic [SET_W-1:0]   set_next;

  // A zero request still runs one set; oversize requests are capped.
  function automatic logic [SET_W-1:0] clamp_sets(input logic [SET_W-1:0] req);
    if (req == '0)
      return SET_W'(1);
    else if (req > SETS_CAP)
      return SETS_CAP;
    else
      return req;
  endfunction

  always_comb begin
    rolling_go = (state == ROLLING) && !stall;
    write_go   = rolling_go && !abort && (cycle_num >= FILL_CYCLES);
    last_row   = (matrix_index == LAST_ROW);
    last_set   = (data_set == SET_W'(sets_lat - 1'b1));
    job_end    = write_go && last_row && last_set;
  end

  always_comb begin
    cycle_inc = (cycle_num == CYC_MAX) ? cycle_num : cycle_num + 1'b1;
    addr_inc  = (addr_serial_num == ADDR_MAX) ? addr_serial_num
                                              : addr_serial_num + 1'b1;
  end

  // Row index wraps at the end of each set and carries into the set counter.
  always_comb begin
    index_next = matrix_index;
    set_next   = data_set;
    if (write_go) begin
      if (last_row) begin
        index_next = '0;
        set_next   = data_set + 1'b1;
      end else begin
        index_next = matrix_index + 1'b1;
      end
    end
  end

  assign busy              = (state != IDLE);
  assign alu_start         = rolling_go;
  assign sram_write_enable = write_go;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state           <= IDLE;
      sets_lat        <= '0;
      addr_serial_num <= '0;
      cycle_num       <= '0;
      matrix_index    <= '0;
      data_set        <= '0;
      tpu_done        <= 1'b0;
    end else begin
      tpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tpu_start) begin
            state           <= LOAD;
            addr_serial_num <= '0;
            sets_lat        <= clamp_sets(num_sets);
          end
        end

        LOAD: begin
          if (abort) begin
            state        <= IDLE;
            cycle_num    <= '0;
            matrix_index <= '0;
            data_set     <= '0;
          end else if (!stall) begin
            state           <= WAIT1;
            addr_serial_num <= ADDR_W'(1);
          end
        end

        WAIT1: begin
          if (abort) begin
            state        <= IDLE;
            cycle_num    <= '0;
            matrix_index <= '0;
            data_set     <= '0;
          end else if (!stall) begin
            state           <= ROLLING;
            addr_serial_num <= ADDR_W'(2);
            cycle_num       <= '0;
          end
        end

        ROLLING: begin
          // Abort beats completion and stall; the address is left where it is.
          if (abort) begin
            state        <= IDLE;
            cycle_num    <= '0;
            matrix_index <= '0;
            data_set     <= '0;
          end else if (!stall) begin
            if (job_end) begin
              state        <= IDLE;
              tpu_done     <= 1'b1;
              cycle_num    <= '0;
              matrix_index <= '0;
              data_set     <= '0;
            end else begin
              cycle_num       <= cycle_inc;
              addr_serial_num <= addr_inc;
              matrix_index    <= index_next;
              data_set        <= set_next;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl_gen.sv
// Directed bench for systolic_ctrl_gen (ARRAY_SIZE=4, ROWS_PER_SET=4, MAX_SETS=4),
// with a second ADDR_W=3 instance sharing the stimulus for address saturation.
module tb_systolic_ctrl_gen;

  logic       clk = 1'b0;
  logic       srstn = 1'b0;
  logic       tpu_start = 1'b0;
  logic [2:0] num_sets = 3'd0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;

  logic       we, alu, busy, done;
  logic [6:0] addr;
  logic [4:0] cyc;
  logic [1:0] idx;
  logic [2:0] dset;

  logic       we_s, alu_s, busy_s, done_s;
  logic [2:0] addr_s;
  logic [4:0] cyc_s;
  logic [1:0] idx_s;
  logic [2:0] dset_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] o_addr[64], o_addr_s[64], o_cyc[64], o_idx[64], o_set[64];
  logic       o_we[64], o_alu[64], o_busy[64], o_done[64];
  int n_wr, n_done, done_k, first_wr_k;

  always #5 clk = ~clk;

  systolic_ctrl_gen #(.ARRAY_SIZE(4), .ROWS_PER_SET(4), .MAX_SETS(4), .ADDR_W(7)) dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .num_sets(num_sets),
    .stall(stall), .abort(abort), .sram_write_enable(we), .addr_serial_num(addr),
    .alu_start(alu), .cycle_num(cyc), .matrix_index(idx), .data_set(dset),
    .busy(busy), .tpu_done(done)
  );

  systolic_ctrl_gen #(.ARRAY_SIZE(4), .ROWS_PER_SET(4), .MAX_SETS(4), .ADDR_W(3)) dut_s (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .num_sets(num_sets),
    .stall(stall), .abort(abort), .sram_write_enable(we_s), .addr_serial_num(addr_s),
    .alu_start(alu_s), .cycle_num(cyc_s), .matrix_index(idx_s), .data_set(dset_s),
    .busy(busy_s), .tpu_done(done_s)
  );

  // Starts a job at edge E0 and records outputs after each edge E_k (k=0..n-1).
  task automatic run_job(input logic [2:0] ns, input int n, input int stall_k,
                         input int stall_n, input int abort_k, input int start_k,
                         input int hold_k);
    num_sets  = ns;
    tpu_start = 1'b1;
    @(posedge clk); #1;
    n_wr = 0; n_done = 0; done_k = -1; first_wr_k = -1;
    for (int k = 0; k < n; k++) begin
      tpu_start = (k == start_k) || (k < hold_k);
      stall     = (k >= stall_k) && (k < stall_k + stall_n);
      abort     = (k == abort_k);
      #1;
      o_addr[k] = 8'(addr);  o_addr_s[k] = 8'(addr_s);
      o_cyc[k]  = 8'(cyc);   o_idx[k]    = 8'(idx);   o_set[k] = 8'(dset);
      o_we[k]   = we;        o_alu[k]    = alu;
      o_busy[k] = busy;      o_done[k]   = done;
      if (we === 1'b1) begin
        n_wr++;
        if (first_wr_k < 0) first_wr_k = k;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k < n - 1) begin
        @(posedge clk); #1;
      end
    end
    tpu_start = 1'b0; stall = 1'b0; abort = 1'b0;
    $display("job num_sets=%0d: writes=%0d done_pulses=%0d first_write_k=%0d done_k=%0d",
             ns, n_wr, n_done, first_wr_k, done_k);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({we, alu, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: we/alu/busy/done=%b expected 0000", {we, alu, busy, done});
    end
    checks++;
    if (addr !== 7'd0 || cyc !== 5'd0 || idx !== 2'd0 || dset !== 3'd0) begin
      errors++;
      $display("FAIL reset_counters: addr=%0d cyc=%0d idx=%0d set=%0d expected all 0",
               addr, cyc, idx, dset);
    end
    @(negedge clk);
    srstn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_nominal();
    int w;
    logic busy_ok;
    run_job(3'd2, 20, -1, 0, -1, 6, 0);
    checks++;
    if (o_addr[0] !== 8'd0 || o_addr[1] !== 8'd1 || o_addr[2] !== 8'd2) begin
      errors++;
      $display("FAIL nominal_addr_seq: got %0d/%0d/%0d expected 0/1/2",
               o_addr[0], o_addr[1], o_addr[2]);
    end
    checks++;
    if (o_cyc[2] !== 8'd0 || o_alu[2] !== 1'b1 || o_alu[1] !== 1'b0) begin
      errors++;
      $display("FAIL nominal_roll_entry: cyc=%0d alu=%b alu_prev=%b expected 0,1,0",
               o_cyc[2], o_alu[2], o_alu[1]);
    end
    checks++;
    if (first_wr_k != 7) begin
      errors++;
      $display("FAIL nominal_first_write: k=%0d expected 7", first_wr_k);
    end
    w = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_we[k] === 1'b1) begin
        checks++;
        if (o_idx[k] !== 8'(w % 4) || o_set[k] !== 8'(w / 4) || o_cyc[k] !== 8'(5 + w)) begin
          errors++;
          $display("FAIL nominal_write_%0d: idx=%0d set=%0d cyc=%0d expected %0d/%0d/%0d",
                   w, o_idx[k], o_set[k], o_cyc[k], w % 4, w / 4, 5 + w);
        end
        w++;
      end
    end
    checks++;
    if (n_wr != 8) begin
      errors++;
      $display("FAIL nominal_write_count: got %0d expected 8", n_wr);
    end
    checks++;
    if (done_k != 15 || n_done != 1 || o_done[16] !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done: k=%0d pulses=%0d next=%b expected k=15 pulses=1 next=0",
               done_k, n_done, o_done[16]);
    end
    busy_ok = 1'b1;
    for (int k = 0; k < 15; k++) if (o_busy[k] !== 1'b1) busy_ok = 1'b0;
    checks++;
    if (busy_ok !== 1'b1 || o_busy[15] !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy: high_E0_E14=%b at_E15=%b expected 1,0", busy_ok, o_busy[15]);
    end
    checks++;
    if (o_addr[15] !== 8'd14 || o_cyc[15] !== 8'd0 || o_idx[15] !== 8'd0 || o_set[15] !== 8'd0) begin
      errors++;
      $display("FAIL nominal_after_done: addr=%0d cyc=%0d idx=%0d set=%0d expected 14,0,0,0",
               o_addr[15], o_cyc[15], o_idx[15], o_set[15]);
    end
  endtask

  task automatic test_stall();
    logic frozen_ok;
    run_job(3'd2, 21, 8, 3, -1, -1, 0);
    frozen_ok = 1'b1;
    for (int k = 8; k < 11; k++)
      if (o_we[k] !== 1'b0 || o_alu[k] !== 1'b0 || o_cyc[k] !== 8'd6 || o_idx[k] !== 8'd1 ||
          o_addr[k] !== 8'd8)
        frozen_ok = 1'b0;
    checks++;
    if (frozen_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_frozen: k8 we=%b alu=%b cyc=%0d idx=%0d addr=%0d expected 0,0,6,1,8",
               o_we[8], o_alu[8], o_cyc[8], o_idx[8], o_addr[8]);
    end
    checks++;
    if (o_we[11] !== 1'b1 || o_cyc[11] !== 8'd6 || o_idx[11] !== 8'd1) begin
      errors++;
      $display("FAIL stall_resume: we=%b cyc=%0d idx=%0d expected 1,6,1",
               o_we[11], o_cyc[11], o_idx[11]);
    end
    checks++;
    if (n_wr != 8 || done_k != 18) begin
      errors++;
      $display("FAIL stall_totals: writes=%0d done_k=%0d expected 8,18", n_wr, done_k);
    end
  endtask

  task automatic test_load_stall();
    run_job(3'd1, 16, 0, 2, -1, -1, 0);
    checks++;
    if (o_addr[1] !== 8'd0 || o_addr[2] !== 8'd0 || o_addr[3] !== 8'd1 || o_addr[4] !== 8'd2) begin
      errors++;
      $display("FAIL load_stall_addr: got %0d/%0d/%0d/%0d expected 0/0/1/2",
               o_addr[1], o_addr[2], o_addr[3], o_addr[4]);
    end
    checks++;
    if (n_wr != 4 || done_k != 13) begin
      errors++;
      $display("FAIL load_stall_totals: writes=%0d done_k=%0d expected 4,13", n_wr, done_k);
    end
  endtask

  task automatic test_clamp();
    run_job(3'd0, 14, -1, 0, -1, -1, 0);
    checks++;
    if (n_wr != 4 || done_k != 11) begin
      errors++;
      $display("FAIL clamp_zero: writes=%0d done_k=%0d expected 4,11", n_wr, done_k);
    end
    run_job(3'd7, 26, -1, 0, -1, -1, 0);
    checks++;
    if (n_wr != 16 || done_k != 23) begin
      errors++;
      $display("FAIL clamp_seven: writes=%0d done_k=%0d expected 16,23", n_wr, done_k);
    end
    checks++;
    if (o_set[22] !== 8'd3 || o_idx[22] !== 8'd3 || o_we[22] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_last_write: set=%0d idx=%0d we=%b expected 3,3,1",
               o_set[22], o_idx[22], o_we[22]);
    end
  endtask

  task automatic test_abort();
    run_job(3'd2, 14, -1, 0, 9, -1, 0);
    checks++;
    if (o_we[9] !== 1'b0 || n_wr != 2) begin
      errors++;
      $display("FAIL abort_write: we_at_abort=%b writes=%0d expected 0,2", o_we[9], n_wr);
    end
    checks++;
    if (o_busy[10] !== 1'b0 || o_cyc[10] !== 8'd0 || o_idx[10] !== 8'd0 || o_set[10] !== 8'd0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b cyc=%0d idx=%0d set=%0d expected 0,0,0,0",
               o_busy[10], o_cyc[10], o_idx[10], o_set[10]);
    end
    checks++;
    if (o_addr[10] !== 8'd9 || o_addr[13] !== 8'd9 || n_done != 0) begin
      errors++;
      $display("FAIL abort_hold: addr=%0d/%0d done_pulses=%0d expected 9/9,0",
               o_addr[10], o_addr[13], n_done);
    end
  endtask

  task automatic test_addr_sat();
    logic sat_ok;
    run_job(3'd4, 26, -1, 0, -1, -1, 0);
    checks++;
    if (o_addr_s[6] !== 8'd6 || o_addr_s[7] !== 8'd7) begin
      errors++;
      $display("FAIL addr_sat_reach: r4=%0d r5=%0d expected 6,7", o_addr_s[6], o_addr_s[7]);
    end
    sat_ok = 1'b1;
    for (int k = 7; k < 26; k++) if (o_addr_s[k] !== 8'd7) sat_ok = 1'b0;
    checks++;
    if (sat_ok !== 1'b1 || o_addr[25] !== 8'd22 || done_k != 23) begin
      errors++;
      $display("FAIL addr_sat_hold: held7=%b wide_addr=%0d done_k=%0d expected 1,22,23",
               sat_ok, o_addr[25], done_k);
    end
  endtask

  task automatic test_idle_inputs();
    stall = 1'b1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || addr !== 7'd22 || addr_s !== 3'd7 || we !== 1'b0) begin
      errors++;
      $display("FAIL idle_inputs: busy=%b done=%b addr=%0d addr_s=%0d we=%b expected 0,0,22,7,0",
               busy, done, addr, addr_s, we);
    end
    stall = 1'b0;
    abort = 1'b0;
    $display("idle stall/abort applied for 3 cycles");
  endtask

  task automatic test_async_reset();
    run_job(3'd2, 11, -1, 0, -1, -1, 0);
    checks++;
    if (o_we[10] !== 1'b1 || o_idx[10] !== 8'd3) begin
      errors++;
      $display("FAIL async_pre: we=%b idx=%0d expected 1,3", o_we[10], o_idx[10]);
    end
    srstn = 1'b0;
    #1;
    checks++;
    if ({we, alu, busy, done} !== 4'b0000 || addr !== 7'd0 || cyc !== 5'd0 ||
        idx !== 2'd0 || dset !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: we/alu/busy/done=%b addr=%0d cyc=%0d idx=%0d set=%0d expected 0",
               {we, alu, busy, done}, addr, cyc, idx, dset);
    end
    @(negedge clk);
    srstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_after: done=%b busy=%b expected 0,0", done, busy);
    end
    $display("async reset applied mid-write");
  endtask

  task automatic test_back_to_back();
    run_job(3'd1, 26, -1, 0, -1, -1, 13);
    checks++;
    if (o_done[11] !== 1'b1 || o_busy[11] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b busy=%b expected 1,0", o_done[11], o_busy[11]);
    end
    checks++;
    if (o_busy[12] !== 1'b1 || o_addr[12] !== 8'd0 || o_addr_s[12] !== 8'd0 || o_done[12] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b addr=%0d addr_s=%0d done=%b expected 1,0,0,0",
               o_busy[12], o_addr[12], o_addr_s[12], o_done[12]);
    end
    checks++;
    if (o_done[23] !== 1'b1 || n_done != 2 || n_wr != 8) begin
      errors++;
      $display("FAIL b2b_second_done: done23=%b pulses=%0d writes=%0d expected 1,2,8",
               o_done[23], n_done, n_wr);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_load_stall();
    test_clamp();
    test_abort();
    test_addr_sat();
    test_idle_inputs();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
